// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response channel plus the decode-facing presentation port.
// Handshakes: imem accepts every cycle imem_req_o is high; decode consumes {if_pc_o, if_inst_o} on a
// cycle with if_valid_o=1 and id_stall_i=0, and the head holds stable while id_stall_i=1.
interface inst_fetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_stall_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    modport master (
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
        input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_stall_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
        output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_stall_i
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the PC, issues imem reads, buffers in-order responses for decode.
// Optional macro FETCH_BYPASS_EN presents a response straight to decode when the queue is empty.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    inst_fetch_queue_if.master bus
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam int          CW1 = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic [CW1-1:0] inflight;
    logic           issue;
    logic           rsp_fire;
    logic           rsp_keep;
    logic           head_valid;
    logic           byp_hit;
    logic           byp_consume;
    logic           pop_fifo;
    logic           push;
    logic           out_valid;
    logic [31:0]    out_pc;
    logic [31:0]    out_inst;

    always_comb begin
        inflight   = {1'b0, count_q} + {1'b0, outst_q};
        issue      = !rst_i && !bus.redirect_i && (inflight < CW1'(DEPTH));
        // A response with nothing outstanding is stray (e.g. left over from before reset).
        rsp_fire   = bus.imem_rvalid_i && (outst_q != '0);
        rsp_keep   = rsp_fire && (drop_q == '0) && !bus.redirect_i;
        head_valid = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        byp_hit    = !head_valid && rsp_keep;
`else
        byp_hit    = 1'b0;
`endif
        byp_consume = byp_hit && !bus.id_stall_i;
        pop_fifo    = head_valid && !bus.id_stall_i && !bus.redirect_i;
        push        = rsp_keep && !byp_consume;

        out_valid = head_valid || byp_hit;
        out_pc    = 32'h0;
        out_inst  = NOP;
        if (head_valid) begin
            out_pc   = mem_pc[rd_ptr_q];
            out_inst = mem_inst[rd_ptr_q];
        end else if (byp_hit) begin
            out_pc   = resp_pc_q;
            out_inst = bus.imem_rdata_i;
        end
    end

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = out_valid;
    assign bus.if_pc_o     = out_pc;
    assign bus.if_inst_o   = out_inst;

    // Requests are sequential between redirects, so the next kept response's PC is a running counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else if (bus.redirect_i) begin
            pc_q      <= {bus.redirect_pc_i[31:2], 2'b00};
            resp_pc_q <= {bus.redirect_pc_i[31:2], 2'b00};
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            outst_q   <= outst_q - CW'(rsp_fire);
            drop_q    <= outst_q - CW'(rsp_fire);
        end else begin
            if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            outst_q <= outst_q + CW'(issue) - CW'(rsp_fire);
            if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - 1'b1;
            end
            if (rsp_keep) begin
                resp_pc_q <= resp_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= resp_pc_q;
            mem_inst[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order imem responder, queue-based reference model checked every
// cycle, and directed scenarios with literal expectations (reset, stall, redirect, wrap, mid-run reset).
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i;
    logic rst_i;
    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;
    bit rsp_hold = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    logic [63:0] exp_q[$];      // queued {pc, inst} that decode has not yet taken
    logic [31:0] req_pc_q[$];   // PCs of issued, unanswered requests in order
    int          m_drop;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- imem responder + stimulus driver ----------------
    task automatic cycle_begin();
        @(posedge clk_i);
        #1;
        cyc++;
        bus.redirect_i = 1'b0;
        if (!rsp_hold && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = ~pend_q[0].addr;
            void'(pend_q.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
        end
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            cycle_begin();
            @(negedge clk_i);
            ok = bus.if_valid_o;
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    always @(negedge clk_i) begin
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] rpc;
        bit          rsp;
        bit          keep;
        bit          was_empty;
        bit          pop;

        rsp = 1'b0; keep = 1'b0; rpc = 32'h0;
        if (rst_i) begin
            e_req = 1'b0; e_addr = RESET_PC; e_valid = 1'b0; e_pc = 32'h0; e_inst = NOP;
        end else begin
            e_req  = !bus.redirect_i && ((exp_q.size() + req_pc_q.size()) < DEPTH);
            e_addr = m_pc;
            rsp    = bus.imem_rvalid_i && (req_pc_q.size() != 0);
            rpc    = rsp ? req_pc_q[0] : 32'h0;
            keep   = rsp && (m_drop == 0) && !bus.redirect_i;
            if (exp_q.size() != 0) begin
                e_valid = 1'b1; e_pc = exp_q[0][63:32]; e_inst = exp_q[0][31:0];
            end else if (BYP && keep) begin
                e_valid = 1'b1; e_pc = rpc; e_inst = bus.imem_rdata_i;
            end else begin
                e_valid = 1'b0; e_pc = 32'h0; e_inst = NOP;
            end
        end

        chk("imem_req",  {31'b0, bus.imem_req_o}, {31'b0, e_req});
        chk("imem_addr", bus.imem_addr_o, e_addr);
        chk("if_valid",  {31'b0, bus.if_valid_o}, {31'b0, e_valid});
        chk("if_pc",     bus.if_pc_o, e_pc);
        chk("if_inst",   bus.if_inst_o, e_inst);

        if (!rst_i && bus.imem_req_o) begin
            pend_q.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
        end

        if (rst_i) begin
            exp_q.delete(); req_pc_q.delete(); m_drop = 0; m_pc = RESET_PC;
        end else if (bus.redirect_i) begin
            exp_q.delete();
            if (rsp) void'(req_pc_q.pop_front());
            m_drop = req_pc_q.size();
            m_pc   = bus.redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            was_empty = (exp_q.size() == 0);
            pop       = e_valid && !bus.id_stall_i;
            if (pop && !was_empty) void'(exp_q.pop_front());
            if (rsp) begin
                void'(req_pc_q.pop_front());
                if (m_drop > 0) m_drop--;
                else if (!(BYP && pop && was_empty)) exp_q.push_back({rpc, bus.imem_rdata_i});
            end
            if (e_req) begin
                req_pc_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_i             = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.id_stall_i    = 1'b0;
        m_pc              = RESET_PC;
        m_drop            = 0;

        repeat (3) cycle_begin();
        @(negedge clk_i);
        chk("rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_addr",  bus.imem_addr_o, RESET_PC);
        chk("rst_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("rst_pc",    bus.if_pc_o, 32'h0);
        chk("rst_inst",  bus.if_inst_o, NOP);

        // Sequential fetch from reset, latency 1, no stall.
        cycle_begin();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t1_req0",  {31'b0, bus.imem_req_o}, 32'd1);
        chk("t1_addr0", bus.imem_addr_o, 32'h0);
        chk("t1_valid0", {31'b0, bus.if_valid_o}, 32'd0);
        cycle_begin(); @(negedge clk_i);
        chk("t1_valid1", {31'b0, bus.if_valid_o}, {31'b0, BYP});
        cycle_begin(); @(negedge clk_i);
        chk("t1_pc2",   bus.if_pc_o, BYP ? 32'h4 : 32'h0);
        chk("t1_inst2", bus.if_inst_o, BYP ? 32'hFFFF_FFFB : 32'hFFFF_FFFF);
        cycle_begin(); @(negedge clk_i);
        chk("t1_pc3",   bus.if_pc_o, BYP ? 32'h8 : 32'h4);
        repeat (6) cycle_begin();

        // Decode stall for 10 cycles, then release.
        cycle_begin();
        bus.id_stall_i = 1'b1;
        repeat (9) cycle_begin();
        @(negedge clk_i);
        chk("t2_req_full", {31'b0, bus.imem_req_o}, 32'd0);
        chk("t2_valid",    {31'b0, bus.if_valid_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle_begin();
            bus.id_stall_i = 1'b0;
            @(negedge clk_i);
            chk("t2_pop_valid", {31'b0, bus.if_valid_o}, 32'd1);
        end
        repeat (6) cycle_begin();

        // Redirect to 0x100 with two requests outstanding.
        rsp_hold = 1'b1;
        cycle_begin();
        cycle_begin();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0100;
        rsp_hold          = 1'b0;
        cycle_begin(); @(negedge clk_i);
        chk("t3_flushed", {31'b0, bus.if_valid_o}, 32'd0);
        chk("t3_addr",    bus.imem_addr_o, 32'h0000_0100);
        chk("t3_req",     {31'b0, bus.imem_req_o}, 32'd1);
        wait_valid(12, "t3_wait");
        chk("t3_pc0",   bus.if_pc_o, 32'h0000_0100);
        chk("t3_inst0", bus.if_inst_o, ~32'h0000_0100);
        cycle_begin(); @(negedge clk_i);
        chk("t3_pc1",   bus.if_pc_o, 32'h0000_0104);
        repeat (6) cycle_begin();

        // Misaligned redirect target with a response in the same cycle.
        cycle_begin();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0203;
        @(negedge clk_i);
        chk("t4_req_redirect", {31'b0, bus.imem_req_o}, 32'd0);
        cycle_begin(); @(negedge clk_i);
        chk("t4_addr",  bus.imem_addr_o, 32'h0000_0200);
        chk("t4_req",   {31'b0, bus.imem_req_o}, 32'd1);
        chk("t4_valid", {31'b0, bus.if_valid_o}, 32'd0);
        wait_valid(12, "t4_wait");
        chk("t4_pc",    bus.if_pc_o, 32'h0000_0200);
        repeat (6) cycle_begin();

        // PC wrap and empty-queue fetch latency.
        cycle_begin();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        cycle_begin(); @(negedge clk_i);
        chk("t6_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        chk("t6_req_top",  {31'b0, bus.imem_req_o}, 32'd1);
        cycle_begin(); @(negedge clk_i);
        chk("t6_addr_wrap", bus.imem_addr_o, 32'h0000_0000);
        chk("t6_valid_lat", {31'b0, bus.if_valid_o}, {31'b0, BYP});
        cycle_begin(); @(negedge clk_i);
        chk("t6_valid_next", {31'b0, bus.if_valid_o}, 32'd1);
        chk("t6_pc_next",    bus.if_pc_o, BYP ? 32'h0000_0000 : 32'hFFFF_FFFC);
        repeat (6) cycle_begin();

        // Reset mid-burst with three requests outstanding; stray response after release.
        lat = 3;
        repeat (8) cycle_begin();
        cycle_begin();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t5_req",   {31'b0, bus.imem_req_o}, 32'd0);
        chk("t5_addr",  bus.imem_addr_o, RESET_PC);
        chk("t5_valid", {31'b0, bus.if_valid_o}, 32'd0);
        chk("t5_pc",    bus.if_pc_o, 32'h0);
        chk("t5_inst",  bus.if_inst_o, NOP);
        cycle_begin();
        cycle_begin();
        rst_i = 1'b0;
        pend_q.delete();
        lat               = 1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk_i);
        chk("t5_rel_req",   {31'b0, bus.imem_req_o}, 32'd1);
        chk("t5_rel_addr",  bus.imem_addr_o, RESET_PC);
        chk("t5_rel_valid", {31'b0, bus.if_valid_o}, 32'd0);
        wait_valid(12, "t5_wait");
        chk("t5_first_pc",   bus.if_pc_o, RESET_PC);
        chk("t5_first_inst", bus.if_inst_o, ~RESET_PC);
        repeat (4) cycle_begin();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
